// File: rtl/spi_pkg.sv
// Shared constants for the SPI LED controller.
// Holds the command encodings, field widths, frame width, default channel
// count and a small address range helper used by the decoder.
package spi_pkg;

   localparam int CMD_W        = 8;
   localparam int ADDR_W       = 8;
   localparam int PAYLOAD_W    = 8;
   localparam int FRAME_W      = CMD_W + ADDR_W + PAYLOAD_W;
   localparam int NUM_LEDS_DEF = 8;

   localparam logic [7:0] CMD_NOP      = 8'h00;
   localparam logic [7:0] CMD_LED_SET  = 8'h01;
   localparam logic [7:0] CMD_LED_READ = 8'h02;
   localparam logic [7:0] ADDR_NONE    = 8'hFF;

   // Addresses at or beyond the channel count are silently ignored.
   function automatic bit addr_in_range(input logic [31:0] addr, input int num);
      return addr < 32'(num);
   endfunction

endpackage

// File: rtl/spi_if.sv
// SPI bus bundle.
//   sclk : serial clock from the master
//   cs   : chip select, active low
//   mosi : master-out serial data
//   miso : slave-out serial data
interface spi_if;
   logic sclk;
   logic cs;
   logic mosi;
   logic miso;

   modport slave  (input sclk, input cs, input mosi, output miso);
   modport master (output sclk, output cs, output mosi, input miso);
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end in the sysclk domain.
// Synchronises sclk/cs/mosi, detects edges, shifts in the frame, counts bits
// and shifts the read response out on miso.
//   sysclk, rst        : system clock, synchronous active-high reset
//   sclk, cs, mosi     : raw SPI inputs (asynchronous)
//   miso               : response bit, registered
//   rsp_byte           : response to load when the header completes
//   hdr_cmd/hdr_addr   : header fields, valid in the cycle the 16th bit lands
//   frame_vld          : 1-cycle strobe when the last frame bit lands
//   frm_cmd/addr/payload : complete frame fields, valid with frame_vld
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int CMD_BITS     = CMD_W,
   parameter int ADDR_BITS    = ADDR_W,
   parameter int PAYLOAD_BITS = PAYLOAD_W
)(
   input  logic                    sysclk,
   input  logic                    rst,
   input  logic                    sclk,
   input  logic                    cs,
   input  logic                    mosi,
   output logic                    miso,
   input  logic [PAYLOAD_BITS-1:0] rsp_byte,
   output logic [CMD_BITS-1:0]     hdr_cmd,
   output logic [ADDR_BITS-1:0]    hdr_addr,
   output logic                    frame_vld,
   output logic [CMD_BITS-1:0]     frm_cmd,
   output logic [ADDR_BITS-1:0]    frm_addr,
   output logic [PAYLOAD_BITS-1:0] frm_payload
);

   localparam int HDR_BITS   = CMD_BITS + ADDR_BITS;
   localparam int FRAME_BITS = HDR_BITS + PAYLOAD_BITS;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] HDR_CNT   = CNT_W'(HDR_BITS);
   localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BITS - 1);
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

   // [0],[1] are the synchroniser; [2] is history for edge detection.
   logic [2:0] sclk_sr, cs_sr;
   logic [1:0] mosi_sr;
   logic sclk_s, sclk_d, cs_s, mosi_s;
   logic rise, fall, cs_fall, sample, hdr_stb;
   logic armed;
   logic [CNT_W-1:0]        bit_cnt;
   logic [FRAME_BITS-2:0]   rx_sr;
   logic [FRAME_BITS-1:0]   rx_next;
   logic [PAYLOAD_BITS-1:0] tx_sr;

   assign sclk_s  = sclk_sr[1];
   assign sclk_d  = sclk_sr[2];
   assign cs_s    = cs_sr[1];
   assign mosi_s  = mosi_sr[1];
   assign rise    = sclk_s & ~sclk_d;
   assign fall    = ~sclk_s & sclk_d;
   assign cs_fall = ~cs_s & cs_sr[2];

   // Bits past the frame length are dropped. 'armed' blocks counting until
   // cs has been seen high, so a frame cut by reset is never resumed.
   assign sample  = rise & ~cs_s & armed & (bit_cnt < FRAME_CNT);
   assign rx_next = {rx_sr, mosi_s};
   assign hdr_stb   = sample && (bit_cnt == HDR_LAST);
   assign frame_vld = sample && (bit_cnt == FRAME_LAST);

   assign hdr_cmd     = rx_next[HDR_BITS-1 -: CMD_BITS];
   assign hdr_addr    = rx_next[ADDR_BITS-1:0];
   assign frm_cmd     = rx_next[FRAME_BITS-1 -: CMD_BITS];
   assign frm_addr    = rx_next[PAYLOAD_BITS+ADDR_BITS-1 -: ADDR_BITS];
   assign frm_payload = rx_next[PAYLOAD_BITS-1:0];
   assign miso        = tx_sr[PAYLOAD_BITS-1];

   always_ff @(posedge sysclk) begin
      if (rst) begin
         sclk_sr <= '0;
         cs_sr   <= '0;
         mosi_sr <= '0;
      end else begin
         sclk_sr <= {sclk_sr[1:0], sclk};
         cs_sr   <= {cs_sr[1:0], cs};
         mosi_sr <= {mosi_sr[0], mosi};
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         rx_sr   <= '0;
         bit_cnt <= '0;
         tx_sr   <= '0;
         armed   <= 1'b0;
      end else if (cs_s || cs_fall) begin
         bit_cnt <= '0;
         tx_sr   <= '0;
         armed   <= armed | cs_s;
      end else begin
         if (sample) begin
            rx_sr   <= rx_next[FRAME_BITS-2:0];
            bit_cnt <= bit_cnt + 1'b1;
         end
         // MSB goes out as soon as the header is in; the falling edge that
         // immediately follows must not shift it away, so shifting starts
         // only once the master has sampled it.
         if (hdr_stb)
            tx_sr <= rsp_byte;
         else if (fall && bit_cnt > HDR_CNT)
            tx_sr <= {tx_sr[PAYLOAD_BITS-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/spi_top.sv
// SPI-controlled LED PWM driver.
// Decodes LED_SET / LED_READ frames from spi_slave_if, holds one 7-bit
// brightness per channel and drives each LED from a shared PWM counter.
//   sysclk, rst : system clock, synchronous active-high reset
//   spi         : SPI bus (slave side)
//   led1..led8  : registered PWM outputs for channel addresses 0..7
module spi_top
   import spi_pkg::*;
#(
   parameter int NUM_LEDS     = NUM_LEDS_DEF,
   parameter int CMD_BITS     = CMD_W,
   parameter int ADDR_BITS    = ADDR_W,
   parameter int PAYLOAD_BITS = PAYLOAD_W
)(
   input  logic sysclk,
   input  logic rst,
   spi_if.slave spi,
   output logic led1,
   output logic led2,
   output logic led3,
   output logic led4,
   output logic led5,
   output logic led6,
   output logic led7,
   output logic led8
);

   localparam int BRIGHT_BITS = PAYLOAD_BITS - 1;
   localparam int IDX_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   logic [CMD_BITS-1:0]     hdr_cmd, frm_cmd;
   logic [ADDR_BITS-1:0]    hdr_addr, frm_addr;
   logic [PAYLOAD_BITS-1:0] frm_payload, rsp_byte;
   logic                    frame_vld;
   logic [NUM_LEDS-1:0][BRIGHT_BITS-1:0] bright;
   logic [BRIGHT_BITS-1:0]  pwm_cnt;
   logic [NUM_LEDS-1:0]     led_q;
   logic [7:0]              led_bus;
   logic                    unused_payload_lsb;

   spi_slave_if #(
      .CMD_BITS     (CMD_BITS),
      .ADDR_BITS    (ADDR_BITS),
      .PAYLOAD_BITS (PAYLOAD_BITS)
   ) u_slave (
      .sysclk      (sysclk),
      .rst         (rst),
      .sclk        (spi.sclk),
      .cs          (spi.cs),
      .mosi        (spi.mosi),
      .miso        (spi.miso),
      .rsp_byte    (rsp_byte),
      .hdr_cmd     (hdr_cmd),
      .hdr_addr    (hdr_addr),
      .frame_vld   (frame_vld),
      .frm_cmd     (frm_cmd),
      .frm_addr    (frm_addr),
      .frm_payload (frm_payload)
   );

   // Brightness is stored without the payload LSB.
   assign unused_payload_lsb = frm_payload[0];

   // Read response; only consumed in the cycle the header completes.
   always_comb begin
      rsp_byte = '0;
      if (hdr_cmd == CMD_BITS'(CMD_LED_READ) && addr_in_range(32'(hdr_addr), NUM_LEDS))
         rsp_byte = {bright[hdr_addr[IDX_W-1:0]], 1'b0};
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         bright  <= '0;
         pwm_cnt <= '0;
         led_q   <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (frame_vld && frm_cmd == CMD_BITS'(CMD_LED_SET) &&
             addr_in_range(32'(frm_addr), NUM_LEDS))
            bright[frm_addr[IDX_W-1:0]] <= frm_payload[PAYLOAD_BITS-1:1];
         for (int i = 0; i < NUM_LEDS; i++)
            led_q[i] <= (bright[i] > pwm_cnt);
      end
   end

   always_comb begin
      led_bus = '0;
      for (int i = 0; i < 8; i++)
         if (i < NUM_LEDS) led_bus[i] = led_q[i];
   end

   assign {led8, led7, led6, led5, led4, led3, led2, led1} = led_bus;

endmodule

// File: tb/tb_spi_top.sv
// Randomised self-checking bench for spi_top with a frame-level reference model.
module tb_spi_top;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] led;
   int         n_chk = 0;
   int         n_fail = 0;
   int         half = 5;
   logic [6:0] bright_m [8];

   spi_if bus();

   always #4 clk = ~clk;

   spi_top dut (
      .sysclk (clk),
      .rst    (rst),
      .spi    (bus),
      .led1   (led[0]),
      .led2   (led[1]),
      .led3   (led[2]),
      .led4   (led[3]),
      .led5   (led[4]),
      .led6   (led[5]),
      .led7   (led[6]),
      .led8   (led[7])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic half_wait();
      repeat (half) @(negedge clk);
   endtask

   // Master side of one cs-low window; returns miso bits for frame bits 1..24.
   task automatic spi_xfer(input logic [23:0] word, input int nbits, input bit end_cs,
                           output logic [23:0] cap);
      cap = '0;
      bus.cs = 1'b0;
      half_wait();
      for (int i = 0; i < nbits; i++) begin
         if (i < 24) bus.mosi = word[23-i];
         else        bus.mosi = 1'($urandom);
         half_wait();
         bus.sclk = 1'b1;
         if (i < 24) cap[23-i] = bus.miso;
         half_wait();
         bus.sclk = 1'b0;
      end
      if (end_cs) begin
         half_wait();
         bus.cs   = 1'b1;
         bus.mosi = 1'b0;
         repeat (12) @(negedge clk);
      end
   endtask

   // One frame checked against the model: reads return {brightness,0} for
   // in-range addresses, everything else returns zero; complete LED_SET
   // frames to valid addresses update the model afterwards.
   task automatic frame(input logic [7:0] cmd, input logic [7:0] addr,
                        input logic [7:0] pay, input int nbits);
      logic [23:0] cap;
      logic [7:0]  exp_rsp;
      half = $urandom_range(4, 7);
      exp_rsp = (cmd == 8'h02 && addr < 8) ? {bright_m[addr[2:0]], 1'b0} : 8'h00;
      spi_xfer({cmd, addr, pay}, nbits, 1'b1, cap);
      chk($sformatf("miso_hdr c%0h a%0h", cmd, addr), 32'(cap[23:8]), 32'h0);
      if (nbits >= 24) begin
         chk($sformatf("rsp c%0h a%0h", cmd, addr), 32'(cap[7:0]), 32'(exp_rsp));
         if (cmd == 8'h01 && addr < 8) bright_m[addr[2:0]] = pay[7:1];
      end
   endtask

   // Any 256-cycle window contains exactly two PWM periods.
   task automatic duty_check(input string tag);
      int cnt [8];
      for (int i = 0; i < 8; i++) cnt[i] = 0;
      repeat (256) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) cnt[i] += int'(led[i]);
      end
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s_duty_led%0d", tag, i + 1), 32'(cnt[i]), 32'(2 * int'(bright_m[i])));
   endtask

   task automatic read_all();
      for (int a = 0; a < 8; a++) frame(8'h02, 8'(a), 8'($urandom), 24);
   endtask

   initial begin
      logic [23:0] cap;
      logic [7:0]  c, a;
      int r, nb;
      for (int i = 0; i < 8; i++) bright_m[i] = '0;
      rst = 1'b1; bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
      @(posedge clk); #1;
      chk("reset_led", 32'(led), 32'h0);
      chk("reset_miso", 32'(bus.miso), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // NOP leaves everything dark and quiet
      frame(8'h00, 8'h00, 8'h00, 24);
      duty_check("nop");
      chk("nop_miso", 32'(bus.miso), 32'h0);

      frame(8'h01, 8'h00, 8'h14, 24);
      duty_check("set0");
      frame(8'h01, 8'h07, 8'hFE, 24);
      frame(8'h01, 8'hFF, 8'hFF, 24);
      duty_check("set7_ff");
      frame(8'h02, 8'h07, 8'h00, 24);
      frame(8'h02, 8'h10, 8'h00, 24);

      // truncated frame must not land, the full one must
      frame(8'h01, 8'h03, 8'h16, 12);
      frame(8'h02, 8'h03, 8'h00, 24);
      frame(8'h01, 8'h03, 8'h16, 24);
      frame(8'h02, 8'h03, 8'h00, 24);
      // extra clocks beyond 24 are ignored
      frame(8'h01, 8'h05, 8'h81, 29);
      frame(8'h02, 8'h05, 8'h00, 24);

      // reset in the middle of a frame
      half = 5;
      spi_xfer({8'h01, 8'h02, 8'h50}, 12, 1'b0, cap);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_led", 32'(led), 32'h0);
      chk("midrst_miso", 32'(bus.miso), 32'h0);
      @(negedge clk); rst = 1'b0;
      bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
      for (int i = 0; i < 8; i++) bright_m[i] = '0;
      repeat (10) @(negedge clk);
      duty_check("midrst");
      frame(8'h01, 8'h02, 8'h50, 24);
      frame(8'h02, 8'h02, 8'h00, 24);
      duty_check("post_rst");

      // randomised traffic
      for (int k = 0; k < 24; k++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      c = 8'h01;
         else if (r < 7) c = 8'h02;
         else if (r < 8) c = 8'h00;
         else            c = 8'($urandom);
         a = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 7)) : 8'($urandom);
         r = $urandom_range(0, 5);
         nb = (r == 0) ? $urandom_range(1, 23) : (r == 1) ? $urandom_range(25, 30) : 24;
         frame(c, a, 8'($urandom), nb);
      end
      duty_check("rand");
      read_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
